// File: rtl/bdb_mc_pkg.sv
// Shared types for bdb_multichannel_counter: per-channel debounce states and FIFO event entry.
package bdb_mc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PEND,
        HELD,
        REL_PEND
    } ch_state_e;

    // Sized for the 16-channel maximum; narrower builds use the low bits only.
    localparam int unsigned EV_CH_W = 4;

    typedef struct packed {
        logic [EV_CH_W-1:0] channel;
        logic               is_press;
    } event_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bdb_event_fifo.sv
// Synchronous event FIFO; accepts a write while full when a pop happens in the same cycle.
module bdb_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic wr_en_i,
    input  T     wr_data_i,
    output logic full_o,
    input  logic rd_en_i,
    output logic valid_o,
    output T     rd_data_o
);

    localparam int unsigned    AW      = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE = (AW+1)'(1);

    T            mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_wr;
    logic        do_rd;

    assign valid_o   = (wr_ptr_q != rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd     = rd_en_i && valid_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/bdb_multichannel_counter.sv
// Multichannel button debouncer with saturating press counters and an event FIFO.
// Define BDB_RELEASE_EVENT_EN to also queue release events.
module bdb_multichannel_counter
    import bdb_mc_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned EVENT_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [CHANNELS-1:0]               btn_in,
    input  logic                              count_clear,
    output logic [CHANNELS-1:0]               btn_state,
    output logic [CHANNELS-1:0]               press_pulse,
    output logic [CHANNELS*COUNT_WIDTH-1:0]   count,
    output logic                              event_valid,
    input  logic                              event_ready,
    output logic [idx_width(CHANNELS)-1:0]    event_channel,
    output logic                              event_is_press,
    output logic                              overflow
);

    localparam int unsigned          CH_W      = idx_width(CHANNELS);
    localparam logic [7:0]           HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    ch_state_e           state_q [CHANNELS];
    ch_state_e           state_d [CHANNELS];
    logic [7:0]          qual_q  [CHANNELS];
    logic [7:0]          qual_d  [CHANNELS];
    logic [CHANNELS-1:0] press_q;
    logic [CHANNELS-1:0] press_d;
    logic [CHANNELS-1:0] rel_q;
    logic [CHANNELS-1:0] rel_d;

    logic [CHANNELS-1:0][COUNT_WIDTH-1:0] count_q;
    logic [CHANNELS-1:0][COUNT_WIDTH-1:0] count_d;

    logic [CHANNELS-1:0] pend_press_q;
    logic [CHANNELS-1:0] pend_press_d;
    logic [CHANNELS-1:0] grant_press;
`ifdef BDB_RELEASE_EVENT_EN
    logic [CHANNELS-1:0] pend_rel_q;
    logic [CHANNELS-1:0] pend_rel_d;
    logic [CHANNELS-1:0] grant_rel;
`endif
    logic   found;
    logic   fifo_wr;
    logic   fifo_full;
    logic   pop;
    logic   ovf_q;
    logic   ovf_d;
    event_t wr_ev;
    event_t head_ev;
    logic   unused_head;

    // Per-channel debounce FSM; press/release strobes are registered with the state change.
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            qual_d[c]  = qual_q[c];
            press_d[c] = 1'b0;
            rel_d[c]   = 1'b0;
            unique case (state_q[c])
                IDLE: begin
                    if (sync2_q[c]) begin
                        state_d[c] = PRESS_PEND;
                        qual_d[c]  = 8'd1;
                    end
                end
                PRESS_PEND: begin
                    if (!sync2_q[c]) begin
                        state_d[c] = IDLE;
                    end else if (qual_q[c] == HOLD_LAST) begin
                        state_d[c] = HELD;
                        press_d[c] = 1'b1;
                    end else begin
                        qual_d[c] = qual_q[c] + 8'd1;
                    end
                end
                HELD: begin
                    if (!sync2_q[c]) begin
                        state_d[c] = REL_PEND;
                        qual_d[c]  = 8'd1;
                    end
                end
                REL_PEND: begin
                    if (sync2_q[c]) begin
                        state_d[c] = HELD;
                    end else if (qual_q[c] == HOLD_LAST) begin
                        state_d[c] = IDLE;
                        rel_d[c]   = 1'b1;
                    end else begin
                        qual_d[c] = qual_q[c] + 8'd1;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            btn_state[c] = (state_q[c] == HELD) || (state_q[c] == REL_PEND);
            if (count_clear) begin
                count_d[c] = press_q[c] ? CNT_ONE : '0;
            end else if (press_q[c] && (count_q[c] != '1)) begin
                count_d[c] = count_q[c] + CNT_ONE;
            end else begin
                count_d[c] = count_q[c];
            end
        end
    end

    // Arbiter: lowest pending press first, then (if enabled) lowest pending release.
    always_comb begin
        found       = 1'b0;
        wr_ev       = '0;
        grant_press = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!found && pend_press_q[c]) begin
                found          = 1'b1;
                grant_press[c] = 1'b1;
                wr_ev.channel  = EV_CH_W'(c);
                wr_ev.is_press = 1'b1;
            end
        end
`ifdef BDB_RELEASE_EVENT_EN
        grant_rel = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!found && pend_rel_q[c]) begin
                found          = 1'b1;
                grant_rel[c]   = 1'b1;
                wr_ev.channel  = EV_CH_W'(c);
                wr_ev.is_press = 1'b0;
            end
        end
`endif
        fifo_wr = found && (!fifo_full || pop);
        if (!fifo_wr) begin
            grant_press = '0;
`ifdef BDB_RELEASE_EVENT_EN
            grant_rel   = '0;
`endif
        end
        pend_press_d = (pend_press_q & ~grant_press) | press_q;
        ovf_d        = ovf_q | (|(press_q & pend_press_q & ~grant_press));
`ifdef BDB_RELEASE_EVENT_EN
        pend_rel_d   = (pend_rel_q & ~grant_rel) | rel_q;
        ovf_d        = ovf_d | (|(rel_q & pend_rel_q & ~grant_rel));
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            press_q      <= '0;
            rel_q        <= '0;
            count_q      <= '0;
            pend_press_q <= '0;
            ovf_q        <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                state_q[c] <= IDLE;
                qual_q[c]  <= '0;
            end
        end else begin
            sync1_q      <= btn_in;
            sync2_q      <= sync1_q;
            press_q      <= press_d;
            rel_q        <= rel_d;
            count_q      <= count_d;
            pend_press_q <= pend_press_d;
            ovf_q        <= ovf_d;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                qual_q[c]  <= qual_d[c];
            end
        end
    end

`ifdef BDB_RELEASE_EVENT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_rel_q <= '0;
        end else begin
            pend_rel_q <= pend_rel_d;
        end
    end
`endif

    bdb_event_fifo #(
        .DEPTH (EVENT_DEPTH),
        .T     (event_t)
    ) u_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_en_i   (fifo_wr),
        .wr_data_i (wr_ev),
        .full_o    (fifo_full),
        .rd_en_i   (event_ready),
        .valid_o   (event_valid),
        .rd_data_o (head_ev)
    );

    assign pop           = event_valid && event_ready;
    assign press_pulse   = press_q;
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign event_channel = head_ev.channel[CH_W-1:0];
    assign unused_head   = ^head_ev;
`ifdef BDB_RELEASE_EVENT_EN
    assign event_is_press = head_ev.is_press;
`else
    assign event_is_press = 1'b1;
`endif

endmodule

// File: doc/bdb_multichannel_counter.md
BDB_MULTICHANNEL_COUNTER -- requirements
Module: bdb_multichannel_counter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent button inputs (1..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: minimum consecutive synchronized samples for an effective press or release (2..255).
REQ-003 SHALL have parameter COUNT_WIDTH, default 8: width of each per-channel press counter.
REQ-004 SHALL have parameter EVENT_DEPTH, default 8: event FIFO depth (power of 2, >=2).
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port btn_in, input, CHANNELS: raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have port count_clear, input, 1: synchronous clear of all press counters.
REQ-009 SHALL have port btn_state, output, CHANNELS: debounced level per channel.
REQ-010 SHALL have port press_pulse, output, CHANNELS: one-cycle strobe per effective press.
REQ-011 SHALL have port count, output, CHANNELS*COUNT_WIDTH: packed press counters, channel 0 in the LSBs.
REQ-012 SHALL have ports event_valid (output, 1), event_ready (input, 1), event_channel (output, $clog2(CHANNELS) min 1), event_is_press (output, 1): FIFO read side.
REQ-013 SHALL have port overflow, output, 1: sticky lost-event flag.

Function
REQ-014 SHALL synchronize each btn_in bit through two flops before any use.
REQ-015 SHALL run one FSM per channel: IDLE -> PRESS_PEND on a high sample; PRESS_PEND -> IDLE on a low sample; PRESS_PEND -> HELD on the HOLD_CYCLES-th consecutive high sample; HELD -> REL_PEND on a low sample; REL_PEND -> HELD on a high sample; REL_PEND -> IDLE on the HOLD_CYCLES-th consecutive low sample.
REQ-016 SHALL restart the qualification count at 1 on every return to a PEND state.
REQ-017 SHALL, for btn_in first sampled high at edge N and held, assert press_pulse for the single cycle after edge N+1+HOLD_CYCLES.
REQ-018 SHALL drive btn_state high in HELD and REL_PEND, low otherwise.
REQ-019 SHALL increment the channel counter on press_pulse, saturating at all-ones.
REQ-020 SHALL, on count_clear together with press_pulse on a channel, load that counter with 1; other channels load 0.
REQ-021 SHALL hold one pending-press flag per channel; the arbiter enqueues the lowest-index pending channel, at most one entry per cycle, only when the FIFO is not full.
REQ-022 SHALL set overflow when a new event arrives on a channel whose pending flag of the same type is already set; the pending event is kept and the new one is discarded.
REQ-023 SHALL present the FIFO head on event_channel/event_is_press while event_valid is high; pop on event_valid and event_ready.
REQ-024 SHALL keep event_valid, event_channel and event_is_press stable while event_valid is high and event_ready is low.
REQ-025 SHALL allow enqueue and pop in the same cycle when full, with no loss and no overflow.

Reset
REQ-026 SHALL, when reset is high at a clk edge, clear the synchronizers, set all FSMs to IDLE, and zero the counters, pending flags, FIFO pointers and overflow.
REQ-027 SHALL hold btn_state, press_pulse, event_valid and overflow at 0 during and after reset until new qualified activity.
REQ-028 SHALL discard any partially qualified press when reset is asserted mid-qualification, with no press_pulse.

Configuration
REQ-029 SHALL, with BDB_RELEASE_EVENT_EN defined, also queue release events (event_is_press=0) on REL_PEND -> IDLE, using a separate per-channel pending-release flag; the arbiter serves presses before releases.
REQ-030 SHALL, without BDB_RELEASE_EVENT_EN, queue only press events; event_is_press is tied to 1.

Structure
REQ-031 SHALL place the channel state enum (IDLE, PRESS_PEND, HELD, REL_PEND) and the event struct {channel, is_press} in package bdb_mc_pkg.
REQ-032 SHALL implement the event FIFO as sub-module bdb_event_fifo, parameterised by depth and entry type.

Verification
REQ-033 Channel 0 high for 3 cycles then low -> no press_pulse, count[0]=0, no event.
REQ-034 Channel 0 high for 4 cycles (HOLD_CYCLES=4) -> press_pulse[0] one cycle after edge N+5, count[0]=1, event {0, press}.
REQ-035 Channels 1 and 3 qualify on the same cycle, event_ready=1 -> events channel 1 then channel 3 on consecutive cycles.
REQ-036 event_ready=0 with EVENT_DEPTH=8 and 10 presses across 4 channels -> FIFO holds 8 entries, overflow=1, outputs stable; drain order matches arrival.
REQ-037 COUNT_WIDTH=2 with 5 presses -> count saturates at 3; count_clear on the same cycle as a press -> count=1.
REQ-038 BDB_RELEASE_EVENT_EN defined, press held then released for 4 cycles -> events {ch, press} then {ch, release}; reset mid-PRESS_PEND -> no event.
